button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce_pkg.sv | 35 +++
 rtl/button_debounce_if.sv | 36 +++
 rtl/button_debounce_sync_2ff.sv | 29 ++
 rtl/button_debounce.sv | 220 ++++++++++++++++++++++
 tb/tb_button_debounce.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer.
// State encoding, LED count width and counter sizing live here.
package button_pkg;

    // Width of the event counter that drives the LED bank
    localparam int LED_W = 8;

    // Debouncer FSM states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } bd_state_e;

    // Ceiling log2: smallest r with 2**r >= v
    function automatic int clog2_f(input longint unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Bits needed to hold the values 0..max_val (at least one)
    function automatic int cnt_width(input longint unsigned max_val);
        int w;
        w = clog2_f(max_val + 64'd1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Signal bundle around one debounced push-button.
// master drives the raw button and observes events; slave is the debouncer side.
interface button_debounce_if
    import button_pkg::*;
(
    input logic i_Clk
);

    logic             i_Button;
    logic             o_Level;
    logic             o_Press;
    logic             o_Release;
    logic             o_Repeat;
    logic [LED_W-1:0] o_Count;

    modport master (
        input  i_Clk,
        output i_Button,
        input  o_Level,
        input  o_Press,
        input  o_Release,
        input  o_Repeat,
        input  o_Count
    );

    modport slave (
        input  i_Clk,
        input  i_Button,
        output o_Level,
        output o_Press,
        output o_Release,
        output o_Repeat,
        output o_Count
    );

endinterface

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Both flops take RST_VAL while reset is asserted.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] o_Q
);

    logic [WIDTH-1:0] r_Meta;
    logic [WIDTH-1:0] r_Sync;

    // First flop may go metastable; second flop gives it a cycle to settle
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Meta <= RST_VAL;
            r_Sync <= RST_VAL;
        end else begin
            r_Meta <= i_D;
            r_Sync <= r_Meta;
        end
    end

    assign o_Q = r_Sync;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer with press/release pulses, auto-repeat and an
// 8-bit event counter for the LED bank. All outputs are registered.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Button,
    output logic             o_Level,
    output logic             o_Press,
    output logic             o_Release,
    output logic             o_Repeat,
    output logic [LED_W-1:0] o_Count
);

    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ?
                            REPEAT_DELAY : REPEAT_RATE;

    localparam int DB_W = cnt_width(64'(DEBOUNCE_CYCLES));
    localparam int RP_W = cnt_width(64'(RP_MAX));

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
    localparam logic [RP_W-1:0] RP_DELAY = RP_W'(REPEAT_DELAY);
    localparam logic [RP_W-1:0] RP_RATE  = RP_W'(REPEAT_RATE);
    localparam logic [RP_W-1:0] RP_ONE   = RP_W'(1);

    // With a one-sample window the first differing sample is enough
    localparam bit DB_SINGLE = (DEBOUNCE_CYCLES <= 1);

    // Synchronized button level
    logic w_Sync;

    // Registered state
    bd_state_e        r_State;
    logic [DB_W-1:0]  r_Db_Cnt;
    logic [RP_W-1:0]  r_Rp_Cnt;
    logic             r_Rp_Armed;
    logic             r_Level;
    logic             r_Press;
    logic             r_Release;
    logic             r_Repeat;
    logic [LED_W-1:0] r_Count;

    // Next-state values
    bd_state_e        w_State_Nxt;
    logic [DB_W-1:0]  w_Db_Nxt;
    logic [RP_W-1:0]  w_Rp_Nxt;
    logic             w_Armed_Nxt;
    logic             w_Level_Nxt;
    logic             w_Press_Nxt;
    logic             w_Release_Nxt;
    logic             w_Repeat_Nxt;
    logic [LED_W-1:0] w_Count_Nxt;

    // Helper terms
    logic [DB_W-1:0]  w_Db_Inc;
    logic [RP_W-1:0]  w_Rp_Tgt;
    logic [RP_W-1:0]  w_Rp_Inc;
    logic             w_Db_Done;
    logic             w_Rp_Hit;
    logic             w_Accept_Press;
    logic             w_Accept_Release;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_sync (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_D     (i_Button),
        .o_Q     (w_Sync)
    );

    // Saturating increments; the repeat target switches after the first pulse
    always_comb begin
        w_Db_Inc  = (r_Db_Cnt >= DB_LAST) ? DB_LAST : r_Db_Cnt + DB_ONE;
        w_Db_Done = (w_Db_Inc >= DB_LAST);
        w_Rp_Tgt  = r_Rp_Armed ? RP_RATE : RP_DELAY;
        w_Rp_Inc  = (r_Rp_Cnt >= w_Rp_Tgt) ? w_Rp_Tgt : r_Rp_Cnt + RP_ONE;
        w_Rp_Hit  = (w_Rp_Inc >= w_Rp_Tgt);
    end

    // FSM transitions, debounce window and repeat cadence
    always_comb begin
        w_State_Nxt      = r_State;
        w_Db_Nxt         = r_Db_Cnt;
        w_Rp_Nxt         = r_Rp_Cnt;
        w_Armed_Nxt      = r_Rp_Armed;
        w_Repeat_Nxt     = 1'b0;
        w_Accept_Press   = 1'b0;
        w_Accept_Release = 1'b0;

        unique case (r_State)
            ST_IDLE: begin
                w_Db_Nxt = '0;
                if (w_Sync) begin
                    if (DB_SINGLE) begin
                        w_Accept_Press = 1'b1;
                    end else begin
                        w_State_Nxt = ST_PRESS_DB;
                        w_Db_Nxt    = DB_ONE;
                    end
                end
            end
            ST_PRESS_DB: begin
                if (!w_Sync) begin
                    w_State_Nxt = ST_IDLE;
                    w_Db_Nxt    = '0;
                end else if (w_Db_Done) begin
                    w_Accept_Press = 1'b1;
                end else begin
                    w_Db_Nxt = w_Db_Inc;
                end
            end
            ST_HELD: begin
                if (!w_Sync) begin
                    if (DB_SINGLE) begin
                        w_Accept_Release = 1'b1;
                    end else begin
                        w_State_Nxt = ST_RELEASE_DB;
                        w_Db_Nxt    = DB_ONE;
                    end
                end else if (w_Rp_Hit) begin
                    w_Repeat_Nxt = 1'b1;
                    w_Rp_Nxt     = '0;
                    w_Armed_Nxt  = 1'b1;
                end else begin
                    w_Rp_Nxt = w_Rp_Inc;
                end
            end
            ST_RELEASE_DB: begin
                if (w_Sync) begin
                    // Glitch while held: resume with the repeat count untouched
                    w_State_Nxt = ST_HELD;
                    w_Db_Nxt    = '0;
                end else if (w_Db_Done) begin
                    w_Accept_Release = 1'b1;
                end else begin
                    w_Db_Nxt = w_Db_Inc;
                end
            end
            default: begin
                w_State_Nxt = ST_IDLE;
                w_Db_Nxt    = '0;
            end
        endcase

        if (w_Accept_Press) begin
            w_State_Nxt = ST_HELD;
            w_Db_Nxt    = '0;
            w_Rp_Nxt    = '0;
            w_Armed_Nxt = 1'b0;
        end

        if (w_Accept_Release) begin
            w_State_Nxt = ST_IDLE;
            w_Db_Nxt    = '0;
        end
    end

    // Output pulses, debounced level and the LED event counter
    always_comb begin
        w_Press_Nxt   = w_Accept_Press;
        w_Release_Nxt = w_Accept_Release;
        w_Level_Nxt   = r_Level;
        if (w_Accept_Press) begin
            w_Level_Nxt = 1'b1;
        end else if (w_Accept_Release) begin
            w_Level_Nxt = 1'b0;
        end
        w_Count_Nxt = r_Count;
        if (w_Accept_Press || w_Repeat_Nxt) begin
            w_Count_Nxt = r_Count + LED_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State    <= ST_IDLE;
            r_Db_Cnt   <= '0;
            r_Rp_Cnt   <= '0;
            r_Rp_Armed <= 1'b0;
        end else begin
            r_State    <= w_State_Nxt;
            r_Db_Cnt   <= w_Db_Nxt;
            r_Rp_Cnt   <= w_Rp_Nxt;
            r_Rp_Armed <= w_Armed_Nxt;
        end
    end

    // Registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Level   <= 1'b0;
            r_Press   <= 1'b0;
            r_Release <= 1'b0;
            r_Repeat  <= 1'b0;
            r_Count   <= '0;
        end else begin
            r_Level   <= w_Level_Nxt;
            r_Press   <= w_Press_Nxt;
            r_Release <= w_Release_Nxt;
            r_Repeat  <= w_Repeat_Nxt;
            r_Count   <= w_Count_Nxt;
        end
    end

    assign o_Level   = r_Level;
    assign o_Press   = r_Press;
    assign o_Release = r_Release;
    assign o_Repeat  = r_Repeat;
    assign o_Count   = r_Count;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random button runs,
// compared each cycle against a run-length reference model.
module tb_button_debounce;
    import button_pkg::*;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    button_debounce_if bif (.i_Clk(clk));

    button_debounce #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_Button  (bif.i_Button),
        .o_Level   (bif.o_Level),
        .o_Press   (bif.o_Press),
        .o_Release (bif.o_Release),
        .o_Repeat  (bif.o_Repeat),
        .o_Count   (bif.o_Count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: delay line for the synchronizer, accepted level,
    // length of the current run disagreeing with it, and cumulative held time
    logic       m_ff1, m_sync;
    logic       m_level, m_press, m_rel, m_rep;
    int         m_run, m_held;
    logic [7:0] m_count;

    task automatic model_reset();
        m_ff1   = 1'b0;
        m_sync  = 1'b0;
        m_level = 1'b0;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_rep   = 1'b0;
        m_run   = 0;
        m_held  = 0;
        m_count = 8'h00;
    endtask

    task automatic model_edge(input logic b);
        logic s;
        s       = m_sync;
        m_sync  = m_ff1;
        m_ff1   = b;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_rep   = 1'b0;
        if (s != m_level) begin
            m_run = m_run + 1;
            if (m_run >= D) begin
                m_level = s;
                m_run   = 0;
                if (s) begin
                    m_press = 1'b1;
                    m_held  = 0;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end else begin
            if (m_level && m_run == 0) begin
                m_held = m_held + 1;
                if (m_held == RD ||
                    (m_held > RD && (m_held - RD) % RR == 0)) begin
                    m_rep = 1'b1;
                end
            end
            m_run = 0;
        end
        if (m_press || m_rep) begin
            m_count = m_count + 8'd1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h @%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("level",   {7'b0, bif.o_Level},   {7'b0, m_level});
        chk("press",   {7'b0, bif.o_Press},   {7'b0, m_press});
        chk("release", {7'b0, bif.o_Release}, {7'b0, m_rel});
        chk("repeat",  {7'b0, bif.o_Repeat},  {7'b0, m_rep});
        chk("count",   bif.o_Count,           m_count);
    endtask

    task automatic cycle(input logic b);
        bif.i_Button = b;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(b);
        #1;
        check_all();
    endtask

    task automatic run(input logic b, input int n);
        for (int k = 0; k < n; k++) cycle(b);
    endtask

    // Reset mid-cycle with no clock edge, hold it one edge, release mid-cycle
    task automatic async_reset(input logic b);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        cycle(b);
        rst_n = 1'b1;
    endtask

    initial begin
        bif.i_Button = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all();
        run(1'b0, 3);
        rst_n = 1'b1;

        // Clean press held 40 cycles, then clean release
        run(1'b1, 40);
        run(1'b0, 10);

        // Bouncing press: 1,0,1,1,0 then stable
        cycle(1'b1); cycle(1'b0); cycle(1'b1); cycle(1'b1); cycle(1'b0);
        run(1'b1, 20);
        run(1'b0, 10);

        // Two-cycle low glitch while held
        run(1'b1, 20);
        run(1'b0, 2);
        run(1'b1, 20);
        run(1'b0, 10);

        // Reset two cycles after the first repeat, button kept held
        run(1'b1, 18);
        async_reset(1'b1);
        run(1'b1, 6);
        chk("rst_press", {7'b0, bif.o_Press}, 8'h01);
        chk("rst_count", bif.o_Count, 8'h01);
        run(1'b1, 6);
        run(1'b0, 10);

        // 256 presses from reset wrap the LED counter
        async_reset(1'b0);
        for (int i = 0; i < 255; i++) begin
            run(1'b1, 8);
            run(1'b0, 8);
        end
        chk("pre_wrap", bif.o_Count, 8'hff);
        run(1'b1, 6);
        chk("wrap_press", {7'b0, bif.o_Press}, 8'h01);
        chk("wrap_count", bif.o_Count, 8'h00);
        run(1'b1, 2);
        run(1'b0, 8);

        // Random button runs with occasional long holds and resets
        for (int i = 0; i < 200; i++) begin
            logic b;
            int   n;
            b = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 12);
            if ($urandom_range(0, 5) == 0) n = $urandom_range(15, 45);
            run(b, n);
            if ($urandom_range(0, 40) == 0) async_reset(b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
